// File: rtl/cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_cycle_sequencer
//  Purpose  : Opcode register and per-instruction cycle counter for the 6502
//             core. Produces the {IR,State} index into the microcode table,
//             advancing it from the table's sequencing field, the datapath's
//             branch/page-cross status and the pending interrupt sources.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_cycle_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] din,
    input  logic [1:0] mc_ctl,
    input  logic       branch_taken,
    input  logic       page_cross,
    input  logic       nmi_req,
    input  logic       irq_req,
    input  logic       irq_mask,
    output logic [7:0] IR,
    output logic [2:0] State,
    output logic       sync,
    output logic [1:0] int_kind,
    output logic       seq_err
);

    // Microcode sequencing field encodings
    localparam logic [1:0] c_CTL_ADVANCE = 2'b00;
    localparam logic [1:0] c_CTL_END     = 2'b01;
    localparam logic [1:0] c_CTL_BRANCH  = 2'b10;
    localparam logic [1:0] c_CTL_PAGE    = 2'b11;

    // Sequence source encodings
    localparam logic [1:0] c_KIND_NORMAL = 2'b00;
    localparam logic [1:0] c_KIND_IRQ    = 2'b01;
    localparam logic [1:0] c_KIND_NMI    = 2'b10;
    localparam logic [1:0] c_KIND_RESET  = 2'b11;

    localparam logic [2:0] c_STATE_FETCH = 3'd0;
    localparam logic [2:0] c_STATE_FIRST = 3'd1;
    localparam logic [2:0] c_STATE_LAST  = 3'd7;
    localparam logic [7:0] c_OP_BRK      = 8'h00;

    logic [7:0] ir_q,       ir_d;
    logic [2:0] state_q,    state_d;
    logic [1:0] kind_q,     kind_d;
    logic       seq_err_q,  seq_err_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_prev_q;

    logic       w_is_fetch;
    logic       w_nmi_edge;
    logic       w_advance;
    logic       w_nmi_taken;

    // Resolve the sequencing field and the NMI edge for this cycle
    always_comb begin
        w_is_fetch  = (state_q == c_STATE_FETCH);
        w_nmi_edge  = nmi_req & ~nmi_prev_q;
        w_nmi_taken = w_is_fetch & nmi_pend_q;
        case (mc_ctl)
            c_CTL_ADVANCE: w_advance = 1'b1;
            c_CTL_END:     w_advance = 1'b0;
            c_CTL_BRANCH:  w_advance = branch_taken;
            c_CTL_PAGE:    w_advance = page_cross;
            default:       w_advance = 1'b0;
        endcase
    end

    // Next-state selection: fetch loads opcode/interrupt, execute steps State
    always_comb begin
        ir_d      = ir_q;
        state_d   = state_q;
        kind_d    = kind_q;
        seq_err_d = seq_err_q;

        if (w_is_fetch) begin
            // mc_ctl is meaningless in the fetch cycle; always go to cycle 1
            state_d = c_STATE_FIRST;
            if (nmi_pend_q) begin
                ir_d   = c_OP_BRK;
                kind_d = c_KIND_NMI;
            end else if (irq_req && !irq_mask) begin
                ir_d   = c_OP_BRK;
                kind_d = c_KIND_IRQ;
            end else begin
                ir_d   = din;
                kind_d = c_KIND_NORMAL;
            end
        end else if (w_advance) begin
            if (state_q == c_STATE_LAST) begin
                // Microcode ran off the end of the table: force an end
                state_d   = c_STATE_FETCH;
                seq_err_d = 1'b1;
            end else begin
                state_d = state_q + 3'd1;
            end
        end else begin
            state_d = c_STATE_FETCH;
        end

        // A new edge beats consumption so a back-to-back NMI is never lost
        if (w_nmi_edge) begin
            nmi_pend_d = 1'b1;
        end else if (w_nmi_taken) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end
    end

    // State registers; everything, including the NMI detector, honours ce
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q       <= c_OP_BRK;
            state_q    <= c_STATE_FIRST;
            kind_q     <= c_KIND_RESET;
            seq_err_q  <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b0;
        end else if (ce) begin
            ir_q       <= ir_d;
            state_q    <= state_d;
            kind_q     <= kind_d;
            seq_err_q  <= seq_err_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_req;
        end
    end

    assign IR       = ir_q;
    assign State    = state_q;
    assign int_kind = kind_q;
    assign seq_err  = seq_err_q;
    assign sync     = (state_q == c_STATE_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_cycle_sequencer
//  Purpose  : Self-checking bench for cpu_cycle_sequencer: directed scenarios
//             plus randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] din = 8'h00;
    logic [1:0] mc_ctl = 2'b00;
    logic       branch_taken = 1'b0;
    logic       page_cross = 1'b0;
    logic       nmi_req = 1'b0;
    logic       irq_req = 1'b0;
    logic       irq_mask = 1'b0;
    logic [7:0] IR;
    logic [2:0] State;
    logic       sync;
    logic [1:0] int_kind;
    logic       seq_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the sequencer's architectural state
    logic [7:0] m_ir;
    logic [2:0] m_st;
    logic [1:0] m_kind;
    logic       m_err;
    logic       m_npend;
    logic       m_nprev;

    cpu_cycle_sequencer dut (
        .clk(clk), .reset(reset), .ce(ce), .din(din), .mc_ctl(mc_ctl),
        .branch_taken(branch_taken), .page_cross(page_cross),
        .nmi_req(nmi_req), .irq_req(irq_req), .irq_mask(irq_mask),
        .IR(IR), .State(State), .sync(sync), .int_kind(int_kind),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ir = 8'h00; m_st = 3'd1; m_kind = 2'b11;
        m_err = 1'b0; m_npend = 1'b0; m_nprev = 1'b0;
    endtask

    // One ce edge of the instruction-cycle rules
    task automatic model_edge();
        bit edge_seen;
        bit adv;
        if (!reset || !ce) return;
        edge_seen = nmi_req && !m_nprev;
        if (m_st == 3'd0) begin
            if (m_npend) begin
                m_ir = 8'h00; m_kind = 2'b10; m_npend = edge_seen;
            end else begin
                if (irq_req && !irq_mask) begin m_ir = 8'h00; m_kind = 2'b01; end
                else begin m_ir = din; m_kind = 2'b00; end
                if (edge_seen) m_npend = 1'b1;
            end
            m_st = 3'd1;
        end else begin
            adv = (mc_ctl == 2'b00) || (mc_ctl == 2'b10 && branch_taken) ||
                  (mc_ctl == 2'b11 && page_cross);
            if (!adv) m_st = 3'd0;
            else if (m_st == 3'd7) begin m_st = 3'd0; m_err = 1'b1; end
            else m_st = m_st + 3'd1;
            if (edge_seen) m_npend = 1'b1;
        end
        m_nprev = nmi_req;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ce = 1'b1; mc_ctl = 2'b00; nmi_req = 1'b0; irq_req = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if ({IR, State, int_kind, sync, seq_err} !== {8'h00, 3'd1, 2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: IR=%h State=%0d kind=%b sync=%b err=%b expected 00 1 11 0 0",
                     IR, State, int_kind, sync, seq_err);
        end
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (State !== 3'(k) || IR !== 8'h00 || int_kind !== 2'b11) begin
                failures++;
                $display("FAIL reset_seq: State=%0d IR=%h kind=%b expected State=%0d IR=00 kind=11",
                         State, IR, int_kind, k);
            end
            mc_ctl = (k == 6) ? 2'b01 : 2'b00;
            step();
        end
        checks++;
        if (State !== 3'd0 || sync !== 1'b1) begin
            failures++;
            $display("FAIL reset_end: State=%0d sync=%b expected 0 1", State, sync);
        end
    endtask

    task automatic test_fetch_ce();
        din = 8'hA9; mc_ctl = 2'b00; step();
        checks++;
        if (IR !== 8'hA9 || State !== 3'd1 || int_kind !== 2'b00 || sync !== 1'b0) begin
            failures++;
            $display("FAIL fetch_load: IR=%h State=%0d kind=%b expected A9 1 00", IR, State, int_kind);
        end
        mc_ctl = 2'b01; step();
        checks++;
        if (State !== 3'd0) begin
            failures++;
            $display("FAIL fetch_end: State=%0d expected 0", State);
        end
        // Same sequence at half rate
        din = 8'h5A; ce = 1'b0; step();
        checks++;
        if (State !== 3'd0 || IR !== 8'hA9) begin
            failures++;
            $display("FAIL ce_hold_fetch: State=%0d IR=%h expected 0 A9", State, IR);
        end
        ce = 1'b1; step();
        ce = 1'b0; step();
        checks++;
        if (State !== 3'd1 || IR !== 8'h5A) begin
            failures++;
            $display("FAIL ce_hold_exec: State=%0d IR=%h expected 1 5A", State, IR);
        end
        ce = 1'b1; step();
        checks++;
        if (State !== 3'd0) begin
            failures++;
            $display("FAIL ce_end: State=%0d expected 0", State);
        end
    endtask

    task automatic test_branch();
        // {branch_taken at State2, page_cross at State3, expected path length}
        bit bt_tab [3] = '{1'b1, 1'b0, 1'b1};
        bit pc_tab [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            din = 8'hD0; mc_ctl = 2'b01; step();         // fetch
            mc_ctl = 2'b00; step();                       // 1 -> 2
            mc_ctl = 2'b10; branch_taken = bt_tab[t]; step();
            checks++;
            if (State !== (bt_tab[t] ? 3'd3 : 3'd0) || IR !== 8'hD0) begin
                failures++;
                $display("FAIL branch_resolve[%0d]: State=%0d IR=%h expected State=%0d IR=D0",
                         t, State, IR, bt_tab[t] ? 3 : 0);
            end
            if (bt_tab[t]) begin
                mc_ctl = 2'b11; page_cross = pc_tab[t]; step();
                checks++;
                if (State !== (pc_tab[t] ? 3'd4 : 3'd0)) begin
                    failures++;
                    $display("FAIL page_resolve[%0d]: State=%0d expected %0d",
                             t, State, pc_tab[t] ? 4 : 0);
                end
                if (pc_tab[t]) begin mc_ctl = 2'b01; step(); end
            end
            branch_taken = 1'b0; page_cross = 1'b0;
        end
    endtask

    task automatic test_interrupts();
        din = 8'hEA; mc_ctl = 2'b00; step();              // fetch -> 1
        nmi_req = 1'b1; irq_req = 1'b1; irq_mask = 1'b0; step();  // 1 -> 2
        mc_ctl = 2'b01; step();                           // end
        step();                                           // fetch
        checks++;
        if (IR !== 8'h00 || int_kind !== 2'b10) begin
            failures++;
            $display("FAIL prio_nmi: IR=%h kind=%b expected 00 10", IR, int_kind);
        end
        step(); step();
        checks++;
        if (IR !== 8'h00 || int_kind !== 2'b01) begin
            failures++;
            $display("FAIL prio_irq: IR=%h kind=%b expected 00 01", IR, int_kind);
        end
        irq_mask = 1'b1; din = 8'h4C; step(); step();
        checks++;
        if (IR !== 8'h4C || int_kind !== 2'b00) begin
            failures++;
            $display("FAIL irq_masked: IR=%h kind=%b expected 4C 00", IR, int_kind);
        end
        step();
        nmi_req = 1'b0; irq_req = 1'b0; irq_mask = 1'b0;
    endtask

    task automatic test_nmi_edge();
        int nmi_seqs;
        din = 8'hEA; mc_ctl = 2'b01;
        step(); step();                                   // back at fetch, nmi low sampled
        nmi_req = 1'b1; nmi_seqs = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (State == 3'd1 && int_kind == 2'b10) nmi_seqs++;
            checks++;
            if ({IR, State, int_kind} !== {m_ir, m_st, m_kind}) begin
                failures++;
                $display("FAIL nmi_hold_cycle%0d: IR=%h State=%0d kind=%b model %h %0d %b",
                         c, IR, State, int_kind, m_ir, m_st, m_kind);
            end
        end
        checks++;
        if (nmi_seqs !== 1) begin
            failures++;
            $display("FAIL nmi_hold_count: got %0d NMI sequences expected 1", nmi_seqs);
        end
        nmi_req = 1'b0; step();
        ce = 1'b0; nmi_req = 1'b1; step();
        nmi_req = 1'b0; step();
        ce = 1'b1; nmi_seqs = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (State == 3'd1 && int_kind == 2'b10) nmi_seqs++;
        end
        checks++;
        if (nmi_seqs !== 0) begin
            failures++;
            $display("FAIL nmi_ce_window: got %0d NMI sequences expected 0", nmi_seqs);
        end
        // Edge in the consuming fetch keeps a second NMI pending
        mc_ctl = 2'b00; nmi_req = 1'b1; step();
        mc_ctl = 2'b01; nmi_req = 1'b0; step();
        nmi_req = 1'b1; step();
        checks++;
        if (State !== 3'd1 || int_kind !== 2'b10) begin
            failures++;
            $display("FAIL nmi_first: State=%0d kind=%b expected 1 10", State, int_kind);
        end
        step(); step();
        checks++;
        if (State !== 3'd1 || int_kind !== 2'b10) begin
            failures++;
            $display("FAIL nmi_second: State=%0d kind=%b expected 1 10", State, int_kind);
        end
        nmi_req = 1'b0; step(); step();
        checks++;
        if (int_kind !== 2'b00 || IR !== 8'hEA) begin
            failures++;
            $display("FAIL nmi_after: kind=%b IR=%h expected 00 EA", int_kind, IR);
        end
        step();
    endtask

    task automatic test_overrun();
        int guard = 0;
        mc_ctl = 2'b01;
        while (State != 3'd0 && guard < 10) begin step(); guard++; end
        checks++;
        if (State !== 3'd0) begin
            failures++;
            $display("FAIL overrun_sync: State=%0d expected 0 within 10 cycles", State);
        end
        mc_ctl = 2'b00; step();
        for (int k = 2; k <= 7; k++) begin
            step();
            checks++;
            if (State !== 3'(k) || seq_err !== 1'b0) begin
                failures++;
                $display("FAIL overrun_step: State=%0d err=%b expected %0d 0", State, seq_err, k);
            end
        end
        step();
        checks++;
        if (State !== 3'd0 || seq_err !== 1'b1) begin
            failures++;
            $display("FAIL overrun_wrap: State=%0d err=%b expected 0 1", State, seq_err);
        end
        repeat (3) step();
        checks++;
        if (seq_err !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: err=%b expected 1", seq_err);
        end
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({IR, State, int_kind, sync, seq_err} !== {8'h00, 3'd1, 2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: IR=%h State=%0d kind=%b sync=%b err=%b expected 00 1 11 0 0",
                     IR, State, int_kind, sync, seq_err);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ce           = ($urandom_range(0, 3) != 0);
            din          = 8'($urandom);
            mc_ctl       = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom);
            page_cross   = 1'($urandom);
            if ($urandom_range(0, 5) == 0) nmi_req = ~nmi_req;
            irq_req      = ($urandom_range(0, 3) == 0);
            irq_mask     = 1'($urandom);
            step();
            checks++;
            if ({IR, State, int_kind, seq_err, sync} !== {m_ir, m_st, m_kind, m_err, (m_st == 3'd0)}) begin
                failures++;
                $display("FAIL random_cycle%0d: IR=%h State=%0d kind=%b err=%b sync=%b model %h %0d %b %b",
                         c, IR, State, int_kind, seq_err, sync, m_ir, m_st, m_kind, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_ce();
        test_branch();
        test_interrupts();
        test_nmi_edge();
        test_overrun();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Instruction-cycle sequencer for the NES 6502 core. It owns the opcode register and the per-instruction cycle counter that index the microcode table. It advances them using the table's two-bit sequencing field, the branch/page-cross status from the datapath, and the pending interrupt sources. It sits between the bus/datapath and `MicroCodeTable`: its `IR` and `State` outputs drive the table inputs directly, and the table's control field feeds back as `mc_ctl`.

## Interface
- No parameters; all widths are fixed by the microcode table (IR 8 bits, State 3 bits).
- `clk` in 1: single system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ce` in 1: clock enable. When low, every register holds, including edge detectors.
- `din` in 8: data bus byte; the opcode is sampled from it in fetch cycles.
- `mc_ctl` in 2: microcode sequencing field for the current `{IR,State}`.
  - 00 = advance.
  - 01 = end instruction.
  - 10 = advance if `branch_taken`, else end.
  - 11 = advance if `page_cross`, else end.
- `branch_taken` in 1: branch condition result for the current cycle.
- `page_cross` in 1: effective-address carry into the high byte for the current cycle.
- `nmi_req` in 1: NMI line, active high; its rising edge is latched.
- `irq_req` in 1: IRQ line, level sensitive, active high.
- `irq_mask` in 1: processor I flag; 1 blocks IRQ.
- `IR` out 8: current opcode; to `MicroCodeTable.IR`.
- `State` out 3: cycle index within the instruction; to `MicroCodeTable.State`.
- `sync` out 1: high while `State==0` (opcode fetch cycle).
- `int_kind` out 2: source of the running sequence. 00 = normal opcode, 01 = IRQ, 10 = NMI, 11 = RESET.
- `seq_err` out 1: sticky flag; set when an advance is requested at `State==7`.

## Operation
- Reset values (`reset`=0, asynchronous):
  - `IR`=8'h00, `State`=3'd1, `int_kind`=2'b11.
  - `sync`=0, `seq_err`=0, NMI pending=0, NMI previous sample=0.
  - Leaving reset therefore runs the BRK microcode with the RESET vector. There is no fetch cycle first.
- Every register updates only on a clock edge with `ce`=1.
- Fetch cycle (`State==0`):
  - `mc_ctl` is ignored.
  - Next `State`=1.
  - `IR` and `int_kind` are loaded using this priority:
    1. NMI pending: `IR`=8'h00, `int_kind`=10, NMI pending cleared.
    2. Else if `irq_req`=1 and `irq_mask`=0: `IR`=8'h00, `int_kind`=01.
    3. Else: `IR`=`din`, `int_kind`=00.
- Execute cycles (`State` 1..7):
  - A resolved advance sets `State`=`State`+1.
  - A resolved end sets `State`=0.
  - `IR` and `int_kind` hold.
- Advance at `State==7`:
  - Forced to end (`State`=0).
  - `seq_err` set to 1; it clears only on reset.
- NMI edge detector:
  - Samples `nmi_req` on each `ce` edge.
  - Sets pending on a 0→1 transition.
  - If an edge is detected in the same cycle that pending is consumed, pending remains 1 (set wins).
- IRQ has no latch. It is sampled only in the fetch cycle.
- `sync` is combinational from `State` (`sync` = (`State`==0)).

## Timing
- The microcode index changes exactly one `ce` edge after the decision. `Mout` for the new `{IR,State}` is valid in the following cycle.
- Minimum instruction length is 2 cycles: fetch, then `State` 1 with `mc_ctl`=01.
  - A branch not taken ends at `State` 1 or 2 according to the microcode.
  - A taken branch without page cross ends one cycle later.
  - A taken branch with page cross ends two cycles later.
- With `ce` low for N cycles, the sequence stretches by exactly N cycles. A `nmi_req` pulse that rises and falls entirely within a `ce`-low window is not seen.
- Reset asserted mid-instruction: outputs go to reset values immediately, without waiting for a clock.
- NMI edge to service:
  - The NMI sequence starts at the next fetch cycle after the edge is sampled.
  - An edge sampled in the fetch cycle itself is serviced at the following fetch.

## Test plan
- Reset release:
  - Hold `reset`=0 for 3 cycles, then release with `ce`=1 and `mc_ctl` end at `State` 6.
  - Expect `IR`=00, `int_kind`=11, `State` stepping 1..6, then `State`=0, `sync`=1.
- Normal fetch and clock enable:
  - In a fetch cycle, drive `din`=8'hA9; `mc_ctl`=01 at `State` 1.
  - Expect `IR`=A9, `State` 0→1→0, `int_kind`=00.
  - Repeat with `ce` toggling 1/0: same sequence at half rate.
- Branch resolution:
  - With `IR`=8'hD0, at `State` 2 drive `mc_ctl`=10, `branch_taken`=1; at `State` 3 drive `mc_ctl`=11, `page_cross`=0.
  - Expect `State` 2→3→0.
  - With `branch_taken`=0: expect `State` 2→0.
- Interrupt priority:
  - Raise `nmi_req` and `irq_req` together, `irq_mask`=0, mid-instruction.
  - Expect the next fetch gives `IR`=00, `int_kind`=10.
  - The following fetch gives `int_kind`=01.
  - With `irq_mask`=1, expect `int_kind`=00 and `IR`=`din`.
- NMI edge corner:
  - Hold `nmi_req`=1 for 20 cycles: only one NMI sequence.
  - Pulse `nmi_req` during a `ce`=0 window: no NMI sequence.
  - Produce an edge in the consuming fetch cycle: a second NMI sequence follows.
- Overrun:
  - Drive `mc_ctl`=00 at every `State`.
  - Expect `State` 7→0 wrap, `seq_err`=1, and `seq_err` held until `reset`=0.
